// File: rtl/w5300_bus_responder.sv
// Chip-side model of the W5300 direct-address host bus: synchronised strobes drive a read/write FSM
// over a word register file with a read-only ID word, plus write-event and protocol-error pulses.
module w5300_bus_responder #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 16,
  parameter int                READ_LAT = 2,
  parameter logic [ADDR_W-1:0] ID_ADDR  = 10'h3FE,
  parameter logic [DATA_W-1:0] ID_VALUE = 16'h5300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              we_n,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              proto_err,
  output logic [15:0]       acc_cnt
);

  localparam int                WORD_W  = ADDR_W - 1;
  localparam int                DEPTH   = 1 << WORD_W;
  localparam logic [3:0]        LAT_M1  = 4'(READ_LAT - 1);
  localparam logic [WORD_W-1:0] ID_WORD = ID_ADDR[ADDR_W-1:1];

  typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_DRIVE, S_WR_ACT, S_ERR} state_t;

  state_t              state_q;
  logic [1:0]          cs_sq, rd_sq, we_sq;
  logic [ADDR_W-1:0]   addr_p1_q, addr_p2_q, wa_q, wr_addr_q;
  logic [DATA_W-1:0]   data_p1_q, data_p2_q, wd_q, wr_data_q, rdata_q;
  logic [3:0]          cnt_q;
  logic                data_oe_q, wr_evt_q, proto_err_q;
  logic [15:0]         acc_cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd, wr, commit;
  logic [WORD_W-1:0]   word_p2;

  assign rd      = !cs_sq[1] && !rd_sq[1];
  assign wr      = !cs_sq[1] && !we_sq[1];
  assign word_p2 = addr_p2_q[ADDR_W-1:1];
  assign commit  = (state_q == S_WR_ACT) && !rd && !wr && (wa_q[ADDR_W-1:1] != ID_WORD);

  assign data      = data_oe_q ? rdata_q : {DATA_W{1'bz}};
  assign wr_evt    = wr_evt_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign proto_err = proto_err_q;
  assign acc_cnt   = acc_cnt_q;

  // Address/data pipeline is kept aligned with the strobe synchronisers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sq     <= 2'b11;
      rd_sq     <= 2'b11;
      we_sq     <= 2'b11;
      addr_p1_q <= '0;
      addr_p2_q <= '0;
      data_p1_q <= '0;
      data_p2_q <= '0;
    end else begin
      cs_sq     <= {cs_sq[0], cs_n};
      rd_sq     <= {rd_sq[0], rd_n};
      we_sq     <= {we_sq[0], we_n};
      addr_p1_q <= addr;
      addr_p2_q <= addr_p1_q;
      data_p1_q <= data;
      data_p2_q <= data_p1_q;
    end
  end

  // Register file is deliberately not reset; an in-flight write is dropped by rst.
  always_ff @(posedge clk) begin
    if (commit && !rst) mem[wa_q[ADDR_W-1:1]] <= wd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_oe_q   <= 1'b0;
      rdata_q     <= '0;
      wa_q        <= '0;
      wd_q        <= '0;
      wr_evt_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      proto_err_q <= 1'b0;
      acc_cnt_q   <= '0;
    end else begin
      wr_evt_q    <= 1'b0;
      proto_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd && wr) begin
            proto_err_q <= 1'b1;
            state_q     <= S_ERR;
          end else if (rd) begin
            cnt_q   <= LAT_M1;
            state_q <= S_RD_WAIT;
          end else if (wr) begin
            wa_q    <= addr_p2_q;
            wd_q    <= data_p2_q;
            state_q <= S_WR_ACT;
          end
        end
        S_RD_WAIT: begin
          if (!rd) begin
            state_q <= S_IDLE;
          end else if (wr) begin
            proto_err_q <= 1'b1;
            state_q     <= S_ERR;
          end else if (cnt_q == 4'd0) begin
            rdata_q   <= (word_p2 == ID_WORD) ? ID_VALUE : mem[word_p2];
            data_oe_q <= 1'b1;
            state_q   <= S_RD_DRIVE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RD_DRIVE: begin
          if (!rd) begin
            data_oe_q <= 1'b0;
            acc_cnt_q <= acc_cnt_q + 16'd1;
            state_q   <= S_IDLE;
          end else if (wr) begin
            data_oe_q   <= 1'b0;
            proto_err_q <= 1'b1;
            state_q     <= S_ERR;
          end
        end
        S_WR_ACT: begin
          if (rd) begin
            proto_err_q <= 1'b1;
            state_q     <= S_ERR;
          end else if (wr) begin
            wa_q <= addr_p2_q;
            wd_q <= data_p2_q;
          end else begin
            // ID-word writes still count as bus accesses but raise no event.
            if (wa_q[ADDR_W-1:1] != ID_WORD) begin
              wr_evt_q  <= 1'b1;
              wr_addr_q <= wa_q;
              wr_data_q <= wd_q;
            end
            acc_cnt_q <= acc_cnt_q + 16'd1;
            state_q   <= S_IDLE;
          end
        end
        S_ERR: begin
          data_oe_q <= 1'b0;
          if (!rd && !wr) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
